// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and its in-flight write scoreboard.
package regfile_scoreboard_pkg;

    localparam int R_ZERO = 0;
    localparam int R_RA   = 31;

    function automatic int addr_width(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read ports, issue and writeback signals between ID (master) and the register file (slave).
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = addr_width(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  issue_valid;
    logic [AW-1:0]         issue_dest;
    logic                  issue_ready;
    logic                  wb_valid;
    logic [AW-1:0]         wb_dest;
    logic [XLEN-1:0]       wb_data;
    logic                  flush;

    modport master (
        output rd_addr, issue_valid, issue_dest, wb_valid, wb_dest, wb_data, flush,
        input  rd_data, rd_busy, issue_ready
    );

    modport slave (
        input  rd_addr, issue_valid, issue_dest, wb_valid, wb_dest, wb_data, flush,
        output rd_data, rd_busy, issue_ready
    );

endinterface

// File: rtl/regfile_scoreboard_inflight_cnt.sv
// One register's count of issued-but-not-written-back results; saturates at both ends.
module rf_inflight_cnt #(
    parameter int CNTW = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CNTW-1:0] cnt_o
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Next count: clear wins, a simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNTW{1'b0}};
        end else if (inc_i && !dec_i && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (dec_i && !inc_i && (cnt_q != {CNTW{1'b0}})) begin
            cnt_d = cnt_q - CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= {CNTW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and a per-register in-flight write scoreboard for RAW stalls.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int CNTW  = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    regfile_scoreboard_if.slave  sb_if
);

    localparam int              AW       = addr_width(NREGS);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [AW-1:0]   ADDR_R0  = AW'(R_ZERO);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [CNTW-1:0]       cnt_s  [NREGS];
    logic                  wb_en_s;
    logic                  issue_wb_hit_s;
    logic                  issue_ready_s;
    logic [AW-1:0]         addr_s;
    logic                  hit_s;
    logic [NREAD*XLEN-1:0] rd_data_s;
    logic [NREAD-1:0]      rd_busy_s;

    assign wb_en_s        = sb_if.wb_valid && (sb_if.wb_dest != ADDR_R0);
    assign issue_wb_hit_s = sb_if.wb_valid && (sb_if.wb_dest == sb_if.issue_dest);
    // A writeback retiring the same register frees a slot for this cycle's issue.
    assign issue_ready_s  = !((cnt_s[sb_if.issue_dest] == CNT_MAX) && !issue_wb_hit_s);

    // Architectural register storage; r0 is never written.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
        end else if (wb_en_s) begin
            regs_q[sb_if.wb_dest] <= sb_if.wb_data;
        end
    end

    assign cnt_s[0] = CNT_ZERO;

    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_cnt
            logic inc_s;
            logic dec_s;
            assign inc_s = sb_if.issue_valid && issue_ready_s && (sb_if.issue_dest == AW'(r));
            assign dec_s = wb_en_s && (sb_if.wb_dest == AW'(r));
            rf_inflight_cnt #(.CNTW(CNTW)) u_cnt (
                .CLK   (CLK),
                .RESET (RESET),
                .clr_i (sb_if.flush),
                .inc_i (inc_s),
                .dec_i (dec_s),
                .cnt_o (cnt_s[r])
            );
        end
    endgenerate

    // Read muxes with bypass; bypass is suppressed while in reset so outputs read zero.
    always_comb begin
        rd_data_s = {(NREAD*XLEN){1'b0}};
        rd_busy_s = {NREAD{1'b0}};
        addr_s    = ADDR_R0;
        hit_s     = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            addr_s = sb_if.rd_addr[i*AW +: AW];
            hit_s  = RESET && sb_if.wb_valid && (sb_if.wb_dest == addr_s);
            if (addr_s == ADDR_R0) begin
                rd_data_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[i]              = 1'b0;
            end else if (hit_s) begin
                rd_data_s[i*XLEN +: XLEN] = sb_if.wb_data;
                rd_busy_s[i]              = (cnt_s[addr_s] > CNT_ONE);
            end else begin
                rd_data_s[i*XLEN +: XLEN] = regs_q[addr_s];
                rd_busy_s[i]              = (cnt_s[addr_s] != CNT_ZERO);
            end
        end
    end

    assign sb_if.rd_data     = rd_data_s;
    assign sb_if.rd_busy     = rd_busy_s;
    assign sb_if.issue_ready = issue_ready_s;

endmodule
